// File: rtl/i2c_slave_mem.sv
// I2C target with a small register memory: the first written byte sets the pointer,
// later bytes write/read at the pointer with auto-increment. No clock stretching.
module i2c_slave_mem #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         MEM_AW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  inout  wire               sda_io,
  inout  wire               scl_io,
  input  logic [MEM_AW-1:0] mem_addr_i,
  output logic [7:0]        mem_data_o,
  output logic              wr_strobe_o,
  output logic [MEM_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_WDATA, S_ACK_W, S_RDATA, S_ACK_R, S_WAIT
  } state_t;

  state_t            state;
  logic [1:0]        scl_sync, sda_sync;
  logic              scl_hist, sda_hist;
  logic [7:0]        sreg;
  logic [2:0]        cnt;
  logic              rw, ack_phase, wr_pend, sda_low;
  logic [MEM_AW-1:0] ptr;
  logic [7:0]        mem [DEPTH];

  logic              scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] ptr_inc;

  // NOTE: every flop in this file uses non-blocking assignments so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_io};
      sda_sync <= {sda_sync[0], sda_io};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_hist;
  assign scl_fall = ~scl_s & scl_hist;
  assign start_ev = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_ev  = scl_s & scl_hist & ~sda_hist & sda_s;
  assign rx_byte  = {sreg[6:0], sda_s};
  assign ptr_inc  = ptr + 1'b1;

  // Reset gates the drive combinationally so the line is let go in the reset cycle itself.
  assign sda_io     = (sda_low && !rst_i) ? 1'b0 : 1'bz;
  assign scl_io     = 1'bz;
  assign mem_data_o = mem[mem_addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      rw          <= 1'b0;
      ack_phase   <= 1'b0;
      wr_pend     <= 1'b0;
      sda_low     <= 1'b0;
      ptr         <= '0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      // NOTE: the memory is cleared by reset on purpose, so it is built from
      // flops rather than a RAM macro; keep DEPTH small.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      if (wr_pend) begin
        mem[ptr]    <= sreg;
        wr_strobe_o <= 1'b1;
        wr_addr_o   <= ptr;
        wr_data_o   <= sreg;
        ptr         <= ptr_inc;
        wr_pend     <= 1'b0;
      end

      if (start_ev) begin
        state     <= S_ADDR;
        cnt       <= '0;
        sda_low   <= 1'b0;
        ack_phase <= 1'b0;
        busy_o    <= 1'b1;
      end else if (stop_ev) begin
        state   <= S_IDLE;
        sda_low <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_WAIT: ;
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              sreg <= rx_byte;
              cnt  <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (state == S_ADDR) begin
                  if (sreg[6:0] == SLV_ADDR) begin
                    rw    <= sda_s;
                    state <= S_ACK_A;
                  end else begin
                    state <= S_IDLE;
                  end
                end else if (state == S_PTR) begin
                  ptr   <= rx_byte[MEM_AW-1:0];
                  state <= S_ACK_W;
                end else begin
                  wr_pend <= 1'b1;
                  state   <= S_ACK_W;
                end
              end
            end
          end
          S_ACK_A, S_ACK_W: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= '0;
                if (state == S_ACK_A && rw) begin
                  sreg    <= mem[ptr];
                  sda_low <= ~mem[ptr][7];
                  state   <= S_RDATA;
                end else begin
                  sda_low <= 1'b0;
                  state   <= (state == S_ACK_A) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (cnt == 3'd7) begin
                sda_low   <= 1'b0;
                cnt       <= '0;
                ack_phase <= 1'b0;
                state     <= S_ACK_R;
              end else begin
                sda_low <= ~sreg[6];
                sreg    <= {sreg[6:0], 1'b0};
                cnt     <= cnt + 3'd1;
              end
            end
          end
          S_ACK_R: begin
            if (scl_rise && !ack_phase) begin
              if (sda_s) begin
                state <= S_WAIT;
              end else begin
                ptr       <= ptr_inc;
                sreg      <= mem[ptr_inc];
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              sda_low   <= ~sreg[7];
              cnt       <= '0;
              ack_phase <= 1'b0;
              state     <= S_RDATA;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
